// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input, which holds the idle line low.
module uart_tx_frame #(
  parameter int CLK_IN    = 12000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_input,
  input  logic                 tx_start,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx_ready,
  output logic                 tx_sending,
  output logic                 tx_done,
  output logic                 tx_output
);

  localparam int DIV   = CLK_IN / BAUD_RATE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_frame: CLK_IN / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_frame: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;

  logic out_next, ready_next, sending_next, done_next;
  logic baud_tick;
  logic accept;
  logic brk;

`ifdef UART_TX_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  assign baud_tick = (cnt_reg == CNT_LAST);
  assign accept    = (state_reg == IDLE) && tx_start && !brk;

  // State and datapath registers, plus the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_output  <= 1'b1;
      tx_ready   <= 1'b1;
      tx_sending <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_output  <= out_next;
      tx_ready   <= ready_next;
      tx_sending <= sending_next;
      tx_done    <= done_next;
    end
  end

  // Next-state logic; idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;

    if (state_reg == IDLE) begin
      cnt_next = '0;
      idx_next = '0;
      if (accept) begin
        state_next  = START;
        shift_next  = tx_input;
        parity_next = PAR_ODD ? ~(^tx_input) : ^tx_input;
      end
    end else begin
      cnt_next = baud_tick ? '0 : cnt_reg + 1'b1;
      if (baud_tick) begin
        case (state_reg)
          START: begin
            state_next = DATA;
            idx_next   = '0;
          end
          DATA: begin
            if (idx_reg == DATA_LAST) begin
              state_next = PAR_EN ? PAR : STOP;
              idx_next   = '0;
            end else begin
              idx_next   = idx_reg + 1'b1;
              shift_next = shift_reg >> 1;
            end
          end
          PAR: begin
            state_next = STOP;
            idx_next   = '0;
          end
          STOP: begin
            if (idx_reg == STOP_LAST) begin
              state_next = IDLE;
              idx_next   = '0;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
            idx_next   = '0;
          end
        endcase
      end
    end
  end

  // Output values are derived from the upcoming state so they register in step with it.
  always_comb begin
    out_next     = 1'b1;
    ready_next   = 1'b0;
    sending_next = 1'b1;
    done_next    = (state_reg == STOP) && (state_next == IDLE);
    case (state_next)
      IDLE: begin
        out_next     = ~brk;
        ready_next   = ~brk;
        sending_next = 1'b0;
      end
      START:   out_next = 1'b0;
      DATA:    out_next = shift_next[0];
      PAR:     out_next = parity_next;
      default: out_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7E2, 7O2) at DIV=4 against a
// cycle-count frame model, plus directed literal checks.
module tb_uart_tx_frame;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       brk = 1'b0;
  logic [2:0] start = '0;
  logic [8:0] din [3];
  logic [2:0] line, rdy, snd, dn;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_IN(16), .BAUD_RATE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst), .tx_input(din[0][7:0]), .tx_start(start[0]),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk),
`endif
    .tx_ready(rdy[0]), .tx_sending(snd[0]), .tx_done(dn[0]), .tx_output(line[0]));

  uart_tx_frame #(.CLK_IN(16), .BAUD_RATE(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(rst), .tx_input(din[1][6:0]), .tx_start(start[1]),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk),
`endif
    .tx_ready(rdy[1]), .tx_sending(snd[1]), .tx_done(dn[1]), .tx_output(line[1]));

  uart_tx_frame #(.CLK_IN(16), .BAUD_RATE(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(rst), .tx_input(din[2][6:0]), .tx_start(start[2]),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk),
`endif
    .tx_ready(rdy[2]), .tx_sending(snd[2]), .tx_done(dn[2]), .tx_output(line[2]));

  function automatic int db_of(input int i);
    return (i == 0) ? 8 : 7;
  endfunction
  function automatic int pm_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction
  function automatic int sb_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // Model: a frame is a list of line bits; cycle k after acceptance shows bit k/DIV.
  bit fb [3][16];
  int nb [3];
  int k  [3];
  bit busy [3];
  bit e_out [3];
  bit e_rdy [3];
  bit e_snd [3];
  bit e_dn  [3];
  bit model_ok = 1'b0;

  function automatic void build(input int i, input int d);
    int n;
    int ones;
    n = 0;
    ones = 0;
    fb[i][n] = 1'b0;
    n++;
    for (int b = 0; b < db_of(i); b++) begin
      fb[i][n] = ((d >> b) & 1) != 0;
      ones += (d >> b) & 1;
      n++;
    end
    if (pm_of(i) != 0) begin
      fb[i][n] = (pm_of(i) == 2) ? ((ones % 2) != 0) : ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < sb_of(i); s++) begin
      fb[i][n] = 1'b1;
      n++;
    end
    nb[i] = n;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        model_ok = 1'b1;
        busy[i]  = 1'b0;
        k[i]     = 0;
        e_out[i] = 1'b1;
        e_rdy[i] = 1'b1;
        e_snd[i] = 1'b0;
        e_dn[i]  = 1'b0;
      end else begin
        e_dn[i] = 1'b0;
        if (busy[i]) begin
          k[i]++;
          if (k[i] == nb[i] * DIV) begin
            busy[i] = 1'b0;
            e_dn[i] = 1'b1;
          end
        end else if (start[i] && !brk) begin
          busy[i] = 1'b1;
          k[i]    = 0;
          build(i, int'(din[i]));
        end
        if (busy[i]) begin
          e_out[i] = fb[i][k[i] / DIV];
          e_rdy[i] = 1'b0;
          e_snd[i] = 1'b1;
        end else begin
          e_out[i] = !brk;
          e_rdy[i] = !brk;
          e_snd[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, i, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        chk("line", i, 32'(line[i]), 32'(e_out[i]));
        chk("ready", i, 32'(rdy[i]), 32'(e_rdy[i]));
        chk("sending", i, 32'(snd[i]), 32'(e_snd[i]));
        chk("done", i, 32'(dn[i]), 32'(e_dn[i]));
      end
    end
  end

  // Sends one frame, samples each bit mid-period and returns the done latency.
  task automatic send_capture(input int i, input logic [8:0] d, input int nbits,
                              output logic [15:0] bits, output int lat);
    bits = '0;
    lat  = -1;
    @(negedge clk);
    din[i]   = d;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    for (int j = 0; j < 200; j++) begin
      if (j == 1) din[i] = ~d;
      if ((j % 4) == 2 && (j / 4) < nbits) bits[j / 4] = line[i];
      if (dn[i]) begin
        lat = j;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] bits;
    int lat;
    int r1, r2, nrise, ndone;
    logic prev;

    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (20) begin
      @(negedge clk);
      chk("idle_line", 0, 32'(line[0]), 32'd1);
      chk("idle_ready", 0, 32'(rdy[0]), 32'd1);
      chk("idle_sending", 0, 32'(snd[0]), 32'd0);
      chk("idle_done", 0, 32'(dn[0]), 32'd0);
    end

    send_capture(0, 9'h0A5, 10, bits, lat);
    chk("a5_bits", 0, 32'(bits), 32'b1101001010);
    chk("a5_latency", 0, lat, 40);
    chk("model_len_8n1", 0, nb[0] * DIV, 40);
    repeat (3) @(negedge clk);

    send_capture(1, 9'h041, 11, bits, lat);
    chk("even_bits", 1, 32'(bits), 32'b11010000010);
    chk("even_latency", 1, lat, 44);
    repeat (3) @(negedge clk);

    send_capture(2, 9'h041, 11, bits, lat);
    chk("odd_bits", 2, 32'(bits), 32'b11110000010);
    chk("odd_latency", 2, lat, 44);
    repeat (3) @(negedge clk);

    // tx_start held high across a whole frame: exactly one extra frame, 1 idle cycle gap.
    r1 = -1;
    r2 = -1;
    nrise = 0;
    prev = snd[0];
    din[0] = 9'h055;
    start[0] = 1'b1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (snd[0] && !prev) begin
        nrise++;
        if (nrise == 1) begin
          r1 = j;
          din[0] = 9'h0AA;
        end else if (nrise == 2) begin
          r2 = j;
          start[0] = 1'b0;
        end
      end
      prev = snd[0];
    end
    start[0] = 1'b0;
    chk("b2b_gap", 0, r2 - r1, 41);
    chk("b2b_frames", 0, nrise, 2);

    // Reset 13 cycles into a frame aborts it without a done pulse.
    @(negedge clk);
    din[1] = 9'h033;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_line", 1, 32'(line[1]), 32'd1);
    chk("abort_ready", 1, 32'(rdy[1]), 32'd1);
    chk("abort_sending", 1, 32'(snd[1]), 32'd0);
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (dn[1]) ndone++;
    end
    chk("abort_no_done", 1, ndone, 0);

`ifdef UART_TX_BREAK_EN
    brk = 1'b1;
    start[0] = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("break_line", 0, 32'(line[0]), 32'd0);
      chk("break_ready", 0, 32'(rdy[0]), 32'd0);
      chk("break_sending", 0, 32'(snd[0]), 32'd0);
    end
    brk = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    chk("release_line", 0, 32'(line[0]), 32'd1);
    chk("release_ready", 0, 32'(rdy[0]), 32'd1);
`endif

    // Random traffic: requests, input churn, occasional resets (and breaks when present).
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        start[i] = ($urandom_range(0, 7) == 0);
        din[i]   = 9'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
`ifdef UART_TX_BREAK_EN
      if ($urandom_range(0, 99) == 0) brk = ~brk;
`endif
    end
    @(negedge clk);
    start = '0;
    rst = 1'b0;
    brk = 1'b0;
    repeat (100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
